axis_width_conv_narrow_wide: RTL and testbench

Packs a stream of narrow M-bit words into N-bit wide words, first narrow word in the most-significant slice. It is the upstream counterpart of the wide-to-narrow converter: it sits between narrow serial-side producers and wide datapath consumers. It uses the same tnext/tvalid/tfirst handshake, a two-page buffer, and a fill-level output.

---
 rtl/axis_width_conv_pkg.sv | 27 ++
 rtl/axis_width_conv_narrow_wide_if.sv | 15 +
 rtl/axis_width_conv_narrow_wide.sv | 135 +++++++++++++
 tb/tb_axis_width_conv_narrow_wide.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_width_conv_pkg.sv
// Purpose: shared width helpers and parameter checks for the AXIS width converters (both directions).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_width_conv_pkg;

  // Number of narrow slots per wide word.
  function automatic int kn_of(input int n, input int m);
    return (m > 0) ? n / m : 0;
  endfunction

  // Width of a slot index, never less than one bit.
  function automatic int slot_w(input int kn);
    return (kn > 1) ? $clog2(kn) : 1;
  endfunction

  // Bits needed to hold a fill level of up to 2*n (two full pages).
  function automatic int bit_count_w(input int n);
    return $clog2(2 * n) + 1;
  endfunction

  // Legal only when M divides N into at least two slots and the
  // two-page fill level fits the 16-bit bit_count port.
  function automatic bit params_ok(input int n, input int m);
    return (m > 0) && (n % m == 0) && (n / m >= 2) && ($clog2(2 * n) <= 15);
  endfunction

endpackage

// File: rtl/axis_width_conv_narrow_wide_if.sv
// Purpose: one tnext/tvalid/tfirst stream of W-bit words.
// Latency: n/a (wiring only).
// Backpressure: tnext is driven by the slave side and marks a taken word.
// Ports: tdata, tfirst, tvalid (master to slave), tnext (slave to master).
interface axis_width_conv_narrow_wide_if #(
  parameter int W = 4
);
  logic         tnext;
  logic [W-1:0] tdata;
  logic         tfirst;
  logic         tvalid;

  modport master (output tdata, output tfirst, output tvalid, input tnext);
  modport slave  (input tdata, input tfirst, input tvalid, output tnext);
endinterface

// File: rtl/axis_width_conv_narrow_wide.sv
// Purpose: packs M-bit narrow beats into N-bit words, first beat in the most-significant slice.
// Latency: a wide word is valid the cycle after its KN-th narrow beat is accepted.
// Backpressure: s_axis.tnext drops while both pages hold committed words; m_axis.tnext frees a page.
// Ports: clk, rst (sync, active-low); s_axis (slave, M-bit narrow input);
//        m_axis (master, N-bit wide output); bit_count (registered fill level: committed + partial bits).
// Option: define AXIS_NW_FLUSH_EN to realign on packet start (mid-word tfirst flushes the partial page).
module axis_width_conv_narrow_wide
  import axis_width_conv_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_width_conv_narrow_wide_if.slave    s_axis,
  axis_width_conv_narrow_wide_if.master   m_axis,
  output logic [15:0]                     bit_count
);

  localparam int KN  = kn_of(N, M);
  localparam int SW  = slot_w(KN);
  localparam int BCW = bit_count_w(N);
  localparam logic [SW-1:0] SLOT_TOP = SW'(KN - 1);

  if (!params_ok(N, M)) begin : g_param_err
    $error("axis_width_conv_narrow_wide: N must be an integer multiple (>=2) of M and 2*N must fit 16 bits");
  end

  typedef struct packed {
    logic [1:0][N-1:0] page;
    logic [1:0]        pfirst;
    logic              wr_page;
    logic              rd_page;
    logic [SW-1:0]     wr_slot;
    logic [1:0]        pages;
    logic [15:0]       bit_count;
  } regs_t;

  localparam regs_t REGS_RST = '{
    page:      '0,
    pfirst:    '0,
    wr_page:   1'b0,
    rd_page:   1'b0,
    wr_slot:   SLOT_TOP,
    pages:     2'd0,
    bit_count: 16'd0
  };

  regs_t          q;
  regs_t          n;
  logic           accept;
  logic           read;
  logic           commit;
  logic           wp;
  logic [SW-1:0]  slot;
  int             lo;
  logic [BCW-1:0] bc;
`ifdef AXIS_NW_FLUSH_EN
  logic           flush_beat;
`endif

  always_comb begin
    n      = q;
    commit = 1'b0;
    wp     = q.wr_page;
    slot   = q.wr_slot;
    lo     = 0;
`ifdef AXIS_NW_FLUSH_EN
    // A packet start landing mid-word closes the partial page first; that
    // needs a free page for the new one, so it is only taken when empty.
    flush_beat = s_axis.tfirst && (q.wr_slot != SLOT_TOP);
    accept     = s_axis.tvalid && rst &&
                 (flush_beat ? (q.pages == 2'd0) : (q.pages != 2'd2));
`else
    accept     = s_axis.tvalid && rst && (q.pages != 2'd2);
`endif
    read = m_axis.tnext && (q.pages != 2'd0);

    if (accept) begin
`ifdef AXIS_NW_FLUSH_EN
      if (flush_beat) begin
        // Unwritten low slots are already zero from the clear at slot KN-1.
        commit = 1'b1;
        wp     = ~q.wr_page;
        slot   = SLOT_TOP;
      end
`endif
      if (slot == SLOT_TOP) begin
        n.page[wp]   = '0;
        n.pfirst[wp] = s_axis.tfirst;
      end
      lo = int'(slot) * M;
      n.page[wp][lo +: M] = s_axis.tdata;
      if (slot == '0) begin
        commit    = 1'b1;
        n.wr_page = ~wp;
        n.wr_slot = SLOT_TOP;
      end else begin
        n.wr_page = wp;
        n.wr_slot = slot - 1'b1;
      end
    end

    if (read) begin
      n.rd_page = ~q.rd_page;
    end

    // Commit and read in the same cycle leave the page count unchanged.
    if (commit && !read) begin
      n.pages = q.pages + 2'd1;
    end else if (read && !commit) begin
      n.pages = q.pages - 2'd1;
    end

    // Registered from the next state so the output tracks the page state
    // established at the most recent edge.
    bc = BCW'(n.pages) * BCW'(N) + BCW'(KN - 1 - int'(n.wr_slot)) * BCW'(M);
    n.bit_count = 16'(bc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= REGS_RST;
    end else begin
      q <= n;
    end
  end

  assign s_axis.tnext  = accept;
  assign m_axis.tvalid = (q.pages != 2'd0);
  assign m_axis.tdata  = q.page[q.rd_page];
  assign m_axis.tfirst = q.pfirst[q.rd_page] && (q.pages != 2'd0);
  assign bit_count     = q.bit_count;

endmodule

// File: tb/tb_axis_width_conv_narrow_wide.sv
// Purpose: directed self-checking bench for the narrow-to-wide packer (N=8/M=4 and N=16/M=4 instances).
// Latency: checks word visibility one cycle after the last narrow beat of a word.
// Backpressure: exercises full-page hold-off, consumer stalls and same-cycle commit/read.
module tb_axis_width_conv_narrow_wide;

`ifdef AXIS_NW_FLUSH_EN
  localparam logic [31:0] T4_W0  = 32'h30;
  localparam logic [31:0] T4_BC  = 32'd16;
  localparam logic [31:0] T4_W1  = 32'h91;
  localparam logic [31:0] T4_F1  = 32'd1;
`else
  localparam logic [31:0] T4_W0  = 32'h39;
  localparam logic [31:0] T4_BC  = 32'd12;
  localparam logic [31:0] T4_W1  = 32'h10;
  localparam logic [31:0] T4_F1  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bc8;
  logic [15:0] bc16;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  axis_width_conv_narrow_wide_if #(.W(4))  s8  ();
  axis_width_conv_narrow_wide_if #(.W(8))  m8  ();
  axis_width_conv_narrow_wide_if #(.W(4))  s16 ();
  axis_width_conv_narrow_wide_if #(.W(16)) m16 ();

  axis_width_conv_narrow_wide #(.N(8), .M(4)) dut8 (
    .clk(clk), .rst(rst), .s_axis(s8), .m_axis(m8), .bit_count(bc8)
  );

  axis_width_conv_narrow_wide #(.N(16), .M(4)) dut16 (
    .clk(clk), .rst(rst), .s_axis(s16), .m_axis(m16), .bit_count(bc16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic [3:0] d, input logic f);
    s8.tvalid = 1'b1;
    s8.tdata  = d;
    s8.tfirst = f;
  endtask

  task automatic idle8();
    s8.tvalid = 1'b0;
    s8.tdata  = 4'h0;
    s8.tfirst = 1'b0;
  endtask

  initial begin
    int         words;
    logic [7:0] exp_w;
    words = 0;

    // Reset: outputs quiet and no accept even with a beat offered.
    rst = 1'b0;
    idle8();
    s8.tvalid  = 1'b1;
    m8.tnext   = 1'b0;
    s16.tvalid = 1'b0;
    s16.tdata  = 4'h0;
    s16.tfirst = 1'b0;
    m16.tnext  = 1'b0;
    adv();
    adv();
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m8.tvalid), 0);
    chk("rst_m_tdata",  32'(m8.tdata), 0);
    chk("rst_m_tfirst", 32'(m8.tfirst), 0);
    chk("rst_bit_count", 32'(bc8), 0);
    chk("rst_s_tnext",  32'(s8.tnext), 0);
    adv();
    rst = 1'b1;
    idle8();

    // 1: 0xA (tfirst) then 0x5 -> 0xA5 with tfirst; fill level 0,4,8,0.
    m8.tnext = 1'b1;
    beat8(4'hA, 1'b1);
    @(negedge clk);
    chk("t1_accept0", 32'(s8.tnext), 1);
    chk("t1_bc0", 32'(bc8), 0);
    adv();
    beat8(4'h5, 1'b0);
    @(negedge clk);
    chk("t1_accept1", 32'(s8.tnext), 1);
    chk("t1_bc1", 32'(bc8), 4);
    chk("t1_vld_early", 32'(m8.tvalid), 0);
    adv();
    idle8();
    @(negedge clk);
    chk("t1_vld", 32'(m8.tvalid), 1);
    chk("t1_dat", 32'(m8.tdata), 32'hA5);
    chk("t1_first", 32'(m8.tfirst), 1);
    chk("t1_bc2", 32'(bc8), 8);
    adv();
    @(negedge clk);
    chk("t1_vld_after", 32'(m8.tvalid), 0);
    chk("t1_bc3", 32'(bc8), 0);
    adv();

    // 2: consumer stalled, beats 1..6; fifth beat held off with both pages full.
    m8.tnext = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      beat8(4'(v), 1'b0);
      @(negedge clk);
      chk("t2_accept", 32'(s8.tnext), 1);
      adv();
    end
    beat8(4'h5, 1'b0);
    @(negedge clk);
    chk("t2_full_tnext", 32'(s8.tnext), 0);
    chk("t2_full_bc", 32'(bc8), 16);
    chk("t2_head", 32'(m8.tdata), 32'h12);
    adv();
    m8.tnext = 1'b1;
    @(negedge clk);
    chk("t2_rd0", 32'(m8.tdata), 32'h12);
    chk("t2_rd0_tnext", 32'(s8.tnext), 0);
    adv();
    @(negedge clk);
    chk("t2_rd1", 32'(m8.tdata), 32'h34);
    chk("t2_beat5", 32'(s8.tnext), 1);
    adv();
    beat8(4'h6, 1'b0);
    @(negedge clk);
    chk("t2_empty", 32'(m8.tvalid), 0);
    chk("t2_beat6", 32'(s8.tnext), 1);
    adv();
    idle8();
    @(negedge clk);
    chk("t2_rd2", 32'(m8.tdata), 32'h56);
    chk("t2_rd2_vld", 32'(m8.tvalid), 1);
    adv();
    @(negedge clk);
    chk("t2_drained", 32'(m8.tvalid), 0);
    adv();

    // 3: 64 back-to-back beats with the consumer always taking words.
    for (int i = 0; i < 64; i++) begin
      beat8(4'(i), 1'b0);
      @(negedge clk);
      chk("t3_accept", 32'(s8.tnext), 1);
      if (m8.tvalid) begin
        exp_w = {4'(2 * words), 4'(2 * words + 1)};
        chk("t3_word", 32'(m8.tdata), 32'(exp_w));
        chk("t3_level", 32'(bc8 <= 16'd12), 1);
        words++;
      end
      adv();
    end
    idle8();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m8.tvalid) begin
        exp_w = {4'(2 * words), 4'(2 * words + 1)};
        chk("t3_word", 32'(m8.tdata), 32'(exp_w));
        words++;
      end
      adv();
    end
    chk("t3_count", 32'(words), 32);

    // 4: 0x3, 0x9 (tfirst), 0x1 -- realigned with flush, packed straight through without.
    m8.tnext = 1'b0;
    beat8(4'h3, 1'b0);
    @(negedge clk);
    chk("t4_a0", 32'(s8.tnext), 1);
    adv();
    beat8(4'h9, 1'b1);
    @(negedge clk);
    chk("t4_a1", 32'(s8.tnext), 1);
    adv();
    beat8(4'h1, 1'b0);
    @(negedge clk);
    chk("t4_w0", 32'(m8.tdata), T4_W0);
    chk("t4_f0", 32'(m8.tfirst), 0);
    chk("t4_v0", 32'(m8.tvalid), 1);
    adv();
    idle8();
    m8.tnext = 1'b1;
    @(negedge clk);
    chk("t4_bc", 32'(bc8), T4_BC);
    adv();
`ifndef AXIS_NW_FLUSH_EN
    beat8(4'h0, 1'b0);
    adv();
    idle8();
`endif
    @(negedge clk);
    chk("t4_w1", 32'(m8.tdata), T4_W1);
    chk("t4_f1", 32'(m8.tfirst), T4_F1);
    chk("t4_v1", 32'(m8.tvalid), 1);
    adv();
    @(negedge clk);
    chk("t4_empty", 32'(m8.tvalid), 0);
    adv();

    // 5: reset with one committed word and a partial word pending.
    m8.tnext = 1'b0;
    beat8(4'h1, 1'b0);
    adv();
    beat8(4'h2, 1'b0);
    adv();
    beat8(4'h3, 1'b0);
    adv();
    idle8();
    @(negedge clk);
    chk("t5_pre_bc", 32'(bc8), 12);
    adv();
    rst = 1'b0;
    beat8(4'hF, 1'b0);
    @(negedge clk);
    chk("t5_rst_tnext", 32'(s8.tnext), 0);
    adv();
    rst = 1'b1;
    idle8();
    @(negedge clk);
    chk("t5_vld", 32'(m8.tvalid), 0);
    chk("t5_bc", 32'(bc8), 0);
    chk("t5_dat", 32'(m8.tdata), 0);
    adv();
    beat8(4'h7, 1'b0);
    adv();
    beat8(4'h8, 1'b0);
    adv();
    idle8();
    @(negedge clk);
    chk("t5_word", 32'(m8.tdata), 32'h78);
    chk("t5_word_vld", 32'(m8.tvalid), 1);
    chk("t5_word_first", 32'(m8.tfirst), 0);
    adv();

    // 6: N=16 instance, four beats -> 0x1234 one cycle after the fourth accept.
    for (int v = 1; v <= 4; v++) begin
      s16.tvalid = 1'b1;
      s16.tdata  = 4'(v);
      s16.tfirst = 1'b0;
      @(negedge clk);
      chk("t6_accept", 32'(s16.tnext), 1);
      chk("t6_vld_early", 32'(m16.tvalid), 0);
      adv();
    end
    s16.tvalid = 1'b0;
    @(negedge clk);
    chk("t6_vld", 32'(m16.tvalid), 1);
    chk("t6_dat", 32'(m16.tdata), 32'h1234);
    chk("t6_bc", 32'(bc16), 16);
    adv();
    m16.tnext = 1'b1;
    adv();
    @(negedge clk);
    chk("t6_drained", 32'(m16.tvalid), 0);
    chk("t6_bc_drained", 32'(bc16), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
